// File: rtl/car_path_controller.sv
// car_path_controller: owns one car's anchor on a horizontal lane and sequences
// the sprite drawer through an erase pass and a redraw pass once per frame tick.
module car_path_controller #(
    parameter int unsigned FRAME_TICKS = 833333,
    parameter logic [7:0]  STEP        = 8'd1,
    parameter logic [7:0]  X_START     = 8'd0,
    parameter logic [6:0]  Y_START     = 7'd50,
    parameter logic [7:0]  X_END       = 8'd140
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       kill,
    input  logic       draw_done,
    output logic       draw_enable,
    output logic       erase_mode,
    output logic       plot,
    output logic [7:0] car_x,
    output logic [6:0] car_y,
    output logic       active,
    output logic       arrived
);

    localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(FRAME_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_DRAW         = 3'd1,
        S_DRAW_SETTLE  = 3'd2,
        S_WAIT         = 3'd3,
        S_ERASE        = 3'd4,
        S_ERASE_SETTLE = 3'd5,
        S_MOVE         = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          kill_pending_q, kill_pending_d;
    logic          kill_flag_q, kill_flag_d;
    logic [7:0]    car_x_q, car_x_d;
    logic [6:0]    car_y_q, car_y_d;
    logic          active_q, active_d;
    logic          arrived_q, arrived_d;
    logic          draw_enable_q, draw_enable_d;
    logic          erase_mode_q, erase_mode_d;
    logic [8:0]    sum_s;
    logic          consume_kill_s;

    // State and output registers; async reset drops the drawer enable at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            tick_q         <= '0;
            kill_pending_q <= 1'b0;
            kill_flag_q    <= 1'b0;
            car_x_q        <= X_START;
            car_y_q        <= Y_START;
            active_q       <= 1'b0;
            arrived_q      <= 1'b0;
            draw_enable_q  <= 1'b0;
            erase_mode_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            tick_q         <= tick_d;
            kill_pending_q <= kill_pending_d;
            kill_flag_q    <= kill_flag_d;
            car_x_q        <= car_x_d;
            car_y_q        <= car_y_d;
            active_q       <= active_d;
            arrived_q      <= arrived_d;
            draw_enable_q  <= draw_enable_d;
            erase_mode_q   <= erase_mode_d;
        end
    end

    // Next-state, anchor update and kill bookkeeping.
    always_comb begin
        state_d        = state_q;
        tick_d         = tick_q;
        kill_pending_d = kill_pending_q;
        kill_flag_d    = kill_flag_q;
        car_x_d        = car_x_q;
        car_y_d        = car_y_q;
        active_d       = active_q;
        arrived_d      = 1'b0;
        sum_s          = {1'b0, car_x_q} + {1'b0, STEP};
        consume_kill_s = (state_q == S_WAIT) && kill_pending_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    car_x_d  = X_START;
                    car_y_d  = Y_START;
                    active_d = 1'b1;
                    state_d  = S_DRAW;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAW: begin
                if (draw_done) begin
                    state_d = S_DRAW_SETTLE;
                end else begin
                    state_d = S_DRAW;
                end
            end
            S_DRAW_SETTLE: begin
                tick_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (kill_pending_q) begin
                    kill_flag_d = 1'b1;
                    tick_d      = '0;
                    state_d     = S_ERASE;
                end else if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    state_d = S_ERASE;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            S_ERASE: begin
                if (draw_done) begin
                    state_d = S_ERASE_SETTLE;
                end else begin
                    state_d = S_ERASE;
                end
            end
            S_ERASE_SETTLE: begin
                if (kill_flag_q) begin
                    active_d    = 1'b0;
                    kill_flag_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_MOVE;
                end
            end
            S_MOVE: begin
                // Saturate at the lane end rather than wrapping the 8-bit anchor.
                if (sum_s >= {1'b0, X_END}) begin
                    car_x_d   = X_END;
                    arrived_d = 1'b1;
                    active_d  = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    car_x_d = sum_s[7:0];
                    state_d = S_DRAW;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_q == S_IDLE) || (state_d == S_IDLE)) begin
            kill_pending_d = 1'b0;
        end else if (consume_kill_s) begin
            kill_pending_d = 1'b0;
        end else if (kill) begin
            kill_pending_d = 1'b1;
        end else begin
            kill_pending_d = kill_pending_q;
        end

        draw_enable_d = (state_d == S_DRAW) || (state_d == S_ERASE);
        erase_mode_d  = (state_d == S_ERASE);
    end

    assign draw_enable = draw_enable_q;
    assign erase_mode  = erase_mode_q;
    assign plot        = draw_enable_q;
    assign car_x       = car_x_q;
    assign car_y       = car_y_q;
    assign active      = active_q;
    assign arrived     = arrived_q;

endmodule

// File: tb/tb_car_path_controller.sv
// Self-checking bench for car_path_controller: cycle table for the first move,
// pass scoreboard fed by a drawer model, and hand sequences for kill/reset/start.
module tb_car_path_controller;

    logic       clk;
    logic       reset;
    logic       start;
    logic       kill;
    logic       draw_done;
    logic       draw_enable;
    logic       erase_mode;
    logic       plot;
    logic [7:0] car_x;
    logic [6:0] car_y;
    logic       active;
    logic       arrived;

    car_path_controller #(
        .FRAME_TICKS(4),
        .STEP       (8'd5),
        .X_START    (8'd0),
        .Y_START    (7'd40),
        .X_END      (8'd20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .kill       (kill),
        .draw_done  (draw_done),
        .draw_enable(draw_enable),
        .erase_mode (erase_mode),
        .plot       (plot),
        .car_x      (car_x),
        .car_y      (car_y),
        .active     (active),
        .arrived    (arrived)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       kill;
        logic [4:0] exp_flags;   // {draw_enable, plot, erase_mode, active, arrived}
        logic [7:0] exp_x;
    } vec_t;

    vec_t        tbl [14];
    logic [15:0] exp_q [$];      // expected passes: {erase_mode, car_x, car_y}
    int          checks;
    int          errors;
    int          dcnt;
    logic        model_done;
    logic        prev_de;
    int          n_draw;
    int          n_erase;
    int          n_arr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] flags_now();
        return {draw_enable, plot, erase_mode, active, arrived};
    endfunction

    function automatic logic [15:0] pass_rec(input logic em, input logic [7:0] x);
        return {em, x, 7'd40};
    endfunction

    // One clock: DUT samples at posedge; monitor, scoreboard and drawer model at negedge.
    task automatic cyc();
        logic [15:0] e;
        @(posedge clk);
        @(negedge clk);
        if (draw_enable && !prev_de) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pass actual=%0h required=none",
                         {erase_mode, car_x, car_y});
            end else begin
                e = exp_q.pop_front();
                chk("pass_scoreboard", {16'd0, erase_mode, car_x, car_y}, {16'd0, e});
            end
            if (erase_mode) n_erase++;
            else n_draw++;
        end
        prev_de = draw_enable;
        if (arrived) n_arr++;
        if (reset || !draw_enable) begin
            dcnt       = 0;
            model_done = 1'b0;
        end else begin
            model_done = (dcnt == 2);
            dcnt       = dcnt + 1;
        end
        draw_done = model_done;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    initial begin
        int c;
        checks = 0; errors = 0; dcnt = 0; model_done = 1'b0; prev_de = 1'b0;
        n_draw = 0; n_erase = 0; n_arr = 0;
        reset = 1'b1; start = 1'b0; kill = 1'b0; draw_done = 1'b0;

        tbl[0]  = '{1'b1, 1'b0, 5'b11010, 8'd0};
        tbl[1]  = '{1'b0, 1'b0, 5'b11010, 8'd0};
        tbl[2]  = '{1'b0, 1'b0, 5'b11010, 8'd0};
        tbl[3]  = '{1'b0, 1'b0, 5'b00010, 8'd0};
        tbl[4]  = '{1'b0, 1'b0, 5'b00010, 8'd0};
        tbl[5]  = '{1'b0, 1'b0, 5'b00010, 8'd0};
        tbl[6]  = '{1'b0, 1'b0, 5'b00010, 8'd0};
        tbl[7]  = '{1'b0, 1'b0, 5'b00010, 8'd0};
        tbl[8]  = '{1'b0, 1'b0, 5'b11110, 8'd0};
        tbl[9]  = '{1'b0, 1'b0, 5'b11110, 8'd0};
        tbl[10] = '{1'b0, 1'b0, 5'b11110, 8'd0};
        tbl[11] = '{1'b0, 1'b0, 5'b00010, 8'd0};
        tbl[12] = '{1'b0, 1'b0, 5'b00010, 8'd0};
        tbl[13] = '{1'b0, 1'b0, 5'b11010, 8'd5};

        run(2);
        reset = 1'b0;
        run(1);
        chk("reset_flags", 32'(flags_now()), 32'd0);
        chk("reset_x", 32'(car_x), 32'd0);
        chk("reset_y", 32'(car_y), 32'd40);

        // First move, cycle by cycle, then free run to the lane end.
        for (int x = 0; x < 20; x += 5) begin
            exp_q.push_back(pass_rec(1'b0, 8'(x)));
            exp_q.push_back(pass_rec(1'b1, 8'(x)));
        end
        for (int i = 0; i < 14; i++) begin
            start = tbl[i].start;
            kill  = tbl[i].kill;
            cyc();
            chk($sformatf("vec%0d_flags", i), 32'(flags_now()), 32'(tbl[i].exp_flags));
            chk($sformatf("vec%0d_x", i), 32'(car_x), 32'(tbl[i].exp_x));
        end
        c = 13;
        while (!arrived && c < 200) begin
            cyc();
            c++;
        end
        chk("arrive_cycle", 32'(c), 32'd52);
        chk("arrive_flags", 32'(flags_now()), 32'b00001);
        chk("arrive_x", 32'(car_x), 32'd20);
        cyc();
        chk("arrive_one_cycle", 32'(arrived), 32'd0);
        chk("free_run_draws", 32'(n_draw), 32'd4);
        chk("free_run_erases", 32'(n_erase), 32'd4);
        chk("free_run_queue", 32'(exp_q.size()), 32'd0);

        // Kill mid-DRAW at x=5: pass completes, erase follows from the next WAIT.
        n_draw = 0; n_erase = 0; n_arr = 0;
        exp_q.push_back(pass_rec(1'b0, 8'd0));
        exp_q.push_back(pass_rec(1'b1, 8'd0));
        exp_q.push_back(pass_rec(1'b0, 8'd5));
        exp_q.push_back(pass_rec(1'b1, 8'd5));
        start = 1'b1; cyc(); start = 1'b0;
        run(13);
        chk("kill_draw_pre", 32'({flags_now(), car_x}), 32'({5'b11010, 8'd5}));
        kill = 1'b1; cyc(); kill = 1'b0;
        chk("kill_draw_continues", 32'(draw_enable), 32'd1);
        run(3);
        chk("kill_draw_wait", 32'(flags_now()), 32'b00010);
        cyc();
        chk("kill_draw_erase", 32'({flags_now(), car_x}), 32'({5'b11110, 8'd5}));
        run(4);
        chk("kill_draw_idle", 32'({flags_now(), car_x}), 32'({5'b00000, 8'd5}));
        run(10);
        chk("kill_no_arrive", 32'(n_arr), 32'd0);
        chk("kill_passes", 32'({n_draw[7:0], n_erase[7:0]}), 32'({8'd2, 8'd2}));

        // Kill in WAIT: erase on the following cycle.
        exp_q.push_back(pass_rec(1'b0, 8'd0));
        exp_q.push_back(pass_rec(1'b1, 8'd0));
        start = 1'b1; cyc(); start = 1'b0;
        run(4);
        kill = 1'b1; cyc(); kill = 1'b0;
        chk("kill_wait_c5", 32'(draw_enable), 32'd0);
        cyc();
        chk("kill_wait_erase", 32'(flags_now()), 32'b11110);
        run(4);
        chk("kill_wait_idle", 32'({flags_now(), car_x}), 32'({5'b00000, 8'd0}));

        // Kill in IDLE is dropped: next start gets a full 4-cycle WAIT.
        kill = 1'b1; cyc(); kill = 1'b0;
        run(3);
        exp_q.push_back(pass_rec(1'b0, 8'd0));
        exp_q.push_back(pass_rec(1'b1, 8'd0));
        exp_q.push_back(pass_rec(1'b0, 8'd5));
        exp_q.push_back(pass_rec(1'b1, 8'd5));
        start = 1'b1; cyc(); start = 1'b0;
        run(7);
        chk("idle_kill_ignored", 32'(flags_now()), 32'b00010);
        cyc();
        chk("idle_kill_erase_on_time", 32'(flags_now()), 32'b11110);
        run(13);
        chk("pre_reset_erase", 32'({flags_now(), car_x}), 32'({5'b11110, 8'd5}));

        // Asynchronous reset in the middle of an erase pass.
        reset = 1'b1;
        #1;
        chk("async_reset_flags", 32'(flags_now()), 32'd0);
        chk("async_reset_xy", 32'({car_x, car_y}), 32'({8'd0, 7'd40}));
        cyc();
        reset = 1'b0;
        run(3);
        chk("post_reset_idle", 32'(flags_now()), 32'd0);
        chk("post_reset_queue", 32'(exp_q.size()), 32'd0);

        // start held through DRAW/WAIT and a spurious draw_done in WAIT.
        exp_q.push_back(pass_rec(1'b0, 8'd0));
        exp_q.push_back(pass_rec(1'b1, 8'd0));
        start = 1'b1;
        run(5);
        chk("start_held_wait", 32'({flags_now(), car_x}), 32'({5'b00010, 8'd0}));
        cyc();
        draw_done = 1'b1;
        cyc();
        chk("spurious_done_ignored", 32'(flags_now()), 32'b00010);
        cyc();
        chk("start_held_c7", 32'({flags_now(), car_x}), 32'({5'b00010, 8'd0}));
        start = 1'b0;
        cyc();
        chk("spurious_erase_on_time", 32'({flags_now(), car_x}), 32'({5'b11110, 8'd0}));
        run(3);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
